// File: rtl/asmd_job_arbiter.sv
// Round-robin arbiter that shares one ASMD counter unit among NREQ requesters, with an F-rise watchdog.
// Optional job/timeout statistics counters are enabled by defining ASMD_ARB_STATS_EN.
module asmd_job_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [NREQ-1:0] done,
   output logic            result_e,
   output logic            timeout_err,
   output logic            busy,
   output logic            unit_start,
   input  logic            unit_f,
   input  logic            unit_e
`ifdef ASMD_ARB_STATS_EN
   ,
   output logic [7:0]      job_cnt,
   output logic [3:0]      tmo_cnt
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      LAUNCH,
      WAIT_CLR,
      WAIT_F,
      REPORT
   } state_t;

   state_t          state;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   pick;
   logic [PW-1:0]   cand;
   logic            pick_valid;
   logic [7:0]      watchdog;

   // Scan from the far end back towards rr_ptr so the last hit is the first requester in round-robin order.
   always_comb begin
      pick       = rr_ptr;
      pick_valid = 1'b0;
      cand       = rr_ptr;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = PW'((int'(rr_ptr) + i) % NREQ);
         if (req[cand]) begin
            pick       = cand;
            pick_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         done        <= '0;
         result_e    <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         unit_start  <= 1'b0;
         rr_ptr      <= '0;
         owner       <= '0;
         watchdog    <= '0;
`ifdef ASMD_ARB_STATS_EN
         job_cnt     <= '0;
         tmo_cnt     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  state <= ARB;
                  busy  <= 1'b1;
               end
            end
            ARB: begin
               if (pick_valid) begin
                  grant      <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                  owner      <= pick;
                  unit_start <= 1'b1;
                  state      <= LAUNCH;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            LAUNCH: begin
               unit_start <= 1'b0;
               watchdog   <= '0;
               state      <= WAIT_CLR;
            end
            // Abort on the edge where the watchdog would step to TIMEOUT-1, so done lands TIMEOUT cycles after LAUNCH.
            WAIT_CLR, WAIT_F: begin
               if (state == WAIT_F && unit_f) begin
                  result_e <= unit_e;
                  done     <= grant;
                  state    <= REPORT;
               end else if (watchdog == 8'(TIMEOUT - 2)) begin
                  result_e    <= 1'b0;
                  done        <= grant;
                  timeout_err <= 1'b1;
                  state       <= REPORT;
               end else begin
                  watchdog <= watchdog + 8'd1;
                  if (state == WAIT_CLR && !unit_f) begin
                     state <= WAIT_F;
                  end
               end
            end
            REPORT: begin
               done        <= '0;
               timeout_err <= 1'b0;
               grant       <= '0;
               busy        <= 1'b0;
               rr_ptr      <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
               state       <= IDLE;
`ifdef ASMD_ARB_STATS_EN
               job_cnt     <= job_cnt + 8'd1;
               if (timeout_err && tmo_cnt != 4'hF) begin
                  tmo_cnt <= tmo_cnt + 4'd1;
               end
`endif
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
